// File: rtl/me_best_match_comparator.sv
// Tracks the minimum PE distance and its motion vector over one NUM_CAND-candidate search.
// All outputs registered (1-cycle latency); no backpressure, CompStart low pauses acceptance.
module me_best_match_comparator #(
  parameter int DIST_W   = 8,
  parameter int VEC_W    = 4,
  parameter int NUM_PE   = 16,
  parameter int NUM_CAND = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            CompStart,
  input  logic [NUM_PE-1:0]               PEready,
  input  logic [DIST_W-1:0]               PEout,
  input  logic [VEC_W-1:0]                VectorX,
  input  logic [VEC_W-1:0]                VectorY,
  output logic [DIST_W-1:0]               BestDist,
  output logic [VEC_W-1:0]                motionX,
  output logic [VEC_W-1:0]                motionY,
  output logic [$clog2(NUM_CAND+1)-1:0]   CandCount,
  output logic                            busy,
  output logic                            done,
  output logic                            protocol_err
);

  localparam int CNT_W = $clog2(NUM_CAND + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_CAND);
  localparam logic [NUM_PE-1:0] PE_ONE   = NUM_PE'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DIST_W-1:0]  best_q, best_d;
  logic [VEC_W-1:0]   mx_q, mx_d, my_q, my_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, perr_q, perr_d;
  logic               seen_low_q, seen_low_d;

  logic               start, qual, pe_any, pe_multi, accept, last;
  logic [DIST_W-1:0]  base_best;
  logic [CNT_W-1:0]   base_cnt;
  logic               base_perr;

  // A restart from DONE needs CompStart to have been low at least once in DONE.
  assign start    = CompStart && ((state_q == S_IDLE) || ((state_q == S_DONE) && seen_low_q));
  assign qual     = CompStart && ((state_q == S_SEARCH) || start);
  assign pe_any   = |PEready;
  assign pe_multi = |(PEready & (PEready - PE_ONE));
  assign accept   = qual && pe_any && !pe_multi;

  assign base_best = start ? {DIST_W{1'b1}} : best_q;
  assign base_cnt  = start ? '0 : cnt_q;
  assign base_perr = start ? 1'b0 : perr_q;
  assign last      = accept && ((base_cnt + CNT_ONE) == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      best_q     <= {DIST_W{1'b1}};
      mx_q       <= '0;
      my_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      best_q     <= best_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      seen_low_q <= seen_low_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = last ? S_DONE : S_SEARCH;
      S_SEARCH: if (last)  state_d = S_DONE;
      S_DONE:   if (start) state_d = last ? S_DONE : S_SEARCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    best_d = base_best;
    mx_d   = mx_q;
    my_d   = my_q;
    cnt_d  = base_cnt;
    perr_d = base_perr;
    if (accept) begin
      if (base_cnt != CNT_LAST) cnt_d = base_cnt + CNT_ONE;
      // Strict less-than keeps the earliest of tied candidates.
      if ((PEout < base_best) || (base_cnt == '0)) begin
        best_d = PEout;
        mx_d   = VectorX;
        my_d   = VectorY;
      end
    end
    if (qual && pe_multi) perr_d = 1'b1;
    busy_d     = (state_d == S_SEARCH);
    done_d     = (state_d == S_DONE);
    seen_low_d = ((state_q == S_DONE) && (state_d == S_DONE)) ? (seen_low_q | ~CompStart) : 1'b0;
  end

  assign BestDist     = best_q;
  assign motionX      = mx_q;
  assign motionY      = my_q;
  assign CandCount    = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_me_best_match_comparator.sv
// Randomized and directed bench for me_best_match_comparator against a per-cycle reference model.
module tb_me_best_match_comparator;

  logic        clock = 1'b0;
  logic        reset, CompStart;
  logic [15:0] PEready;
  logic [7:0]  PEout;
  logic [3:0]  VectorX, VectorY;
  logic [7:0]  BestDist;
  logic [3:0]  motionX, motionY;
  logic [8:0]  CandCount;
  logic        busy, done, protocol_err;

  always #5 clock = ~clock;

  me_best_match_comparator dut (
    .clock(clock), .reset(reset), .CompStart(CompStart), .PEready(PEready), .PEout(PEout),
    .VectorX(VectorX), .VectorY(VectorY), .BestDist(BestDist), .motionX(motionX),
    .motionY(motionY), .CandCount(CandCount), .busy(busy), .done(done),
    .protocol_err(protocol_err)
  );

  localparam int IDLE = 0, SEARCH = 1, DONE_ST = 2;

  int n_checks = 0, n_fail = 0;
  int m_st, m_best, m_mx, m_my, m_cnt, m_perr, m_low;
  logic [7:0] c_dist [256];
  logic [3:0] c_x [256];
  logic [3:0] c_y [256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: one call per rising edge with the inputs sampled there.
  task automatic model_step(input logic rst, input logic cs, input logic [15:0] pr,
                            input logic [7:0] po, input logic [3:0] x, input logic [3:0] y);
    bit start;
    int n;
    if (rst) begin
      m_st = IDLE; m_best = 255; m_mx = 0; m_my = 0; m_cnt = 0; m_perr = 0; m_low = 0;
    end else begin
      start = cs && (m_st == IDLE || (m_st == DONE_ST && m_low == 1));
      if (m_st == DONE_ST && !start) begin
        if (!cs) m_low = 1;
      end else begin
        if (start) begin
          m_st = SEARCH; m_best = 255; m_cnt = 0; m_perr = 0;
        end
        if (m_st == SEARCH && cs) begin
          n = $countones(pr);
          if (n > 1) m_perr = 1;
          else if (n == 1) begin
            if (m_cnt == 0 || int'(po) < m_best) begin
              m_best = int'(po); m_mx = int'(x); m_my = int'(y);
            end
            m_cnt++;
            if (m_cnt == 256) begin
              m_st = DONE_ST; m_low = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("BestDist", 32'(BestDist), 32'(m_best));
    chk("motionX", 32'(motionX), 32'(m_mx));
    chk("motionY", 32'(motionY), 32'(m_my));
    chk("CandCount", 32'(CandCount), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_st == SEARCH));
    chk("done", 32'(done), 32'(m_st == DONE_ST));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));
  endtask

  task automatic cycle(input logic rst, input logic cs, input logic [15:0] pr,
                       input logic [7:0] po, input logic [3:0] x, input logic [3:0] y);
    @(negedge clock);
    reset = rst; CompStart = cs; PEready = pr; PEout = po; VectorX = x; VectorY = y;
    @(posedge clock);
    model_step(rst, cs, pr, po, x, y);
    #1;
    check_all();
  endtask

  function automatic logic [15:0] onehot(input int k);
    logic [15:0] v;
    v = '0;
    v[k % 16] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] multihot();
    logic [15:0] v;
    int a, b;
    a = $urandom_range(15);
    b = (a + 1 + $urandom_range(14)) % 16;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 256; i++) begin
      c_dist[i] = 8'($urandom_range(hi, lo));
      c_x[i] = 4'($urandom_range(15));
      c_y[i] = 4'($urandom_range(15));
    end
  endtask

  // Feeds candidates [lo,hi); gap_pct inserts idle, paused and multi-hot cycles.
  task automatic feed(input int lo, input int hi, input int gap_pct);
    for (int i = lo; i < hi; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        case ($urandom_range(2))
          0: cycle(1'b0, 1'b1, 16'h0, 8'($urandom), 4'($urandom), 4'($urandom));
          1: cycle(1'b0, 1'b0, onehot($urandom_range(15)), 8'($urandom), 4'($urandom), 4'($urandom));
          default: cycle(1'b0, 1'b1, multihot(), 8'($urandom), 4'($urandom), 4'($urandom));
        endcase
      end
      cycle(1'b0, 1'b1, onehot(i), c_dist[i], c_x[i], c_y[i]);
    end
  endtask

  task automatic final_chk(input string tag);
    int bi;
    bi = 0;
    for (int i = 1; i < 256; i++)
      if (c_dist[i] < c_dist[bi]) bi = i;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(CandCount), 32'd256);
    chk({tag, "_best"}, 32'(BestDist), 32'(c_dist[bi]));
    chk({tag, "_mx"}, 32'(motionX), 32'(c_x[bi]));
    chk({tag, "_my"}, 32'(motionY), 32'(c_y[bi]));
  endtask

  task automatic idle_low();
    cycle(1'b0, 1'b0, 16'h0, 8'h0, 4'h0, 4'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int saved_cnt, min10;
    // Reset and idle
    cycle(1'b1, 1'b0, 16'h0, 8'h0, 4'h0, 4'h0);
    cycle(1'b1, 1'b1, 16'h1, 8'h5, 4'h3, 4'h3);
    for (int i = 0; i < 10; i++) idle_low();
    chk("rst_best", 32'(BestDist), 32'hFF);
    chk("rst_mx", 32'(motionX), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(CandCount), 32'd0);

    // Known minimum at index 100
    for (int i = 0; i < 256; i++) begin
      c_dist[i] = 8'd200; c_x[i] = 4'(i % 16); c_y[i] = 4'(i / 16);
    end
    c_dist[100] = 8'd37; c_x[100] = 4'd5; c_y[100] = 4'd11;
    feed(0, 255, 0);
    chk("known_done_early", 32'(done), 32'd0);
    chk("known_cnt255", 32'(CandCount), 32'd255);
    feed(255, 256, 0);
    chk("known_done", 32'(done), 32'd1);
    chk("known_best", 32'(BestDist), 32'd37);
    chk("known_mx", 32'(motionX), 32'd5);
    chk("known_my", 32'(motionY), 32'd11);
    chk("known_cnt", 32'(CandCount), 32'd256);

    // All-max search: first candidate wins ties
    idle_low();
    fill(255, 255);
    c_x[0] = 4'd0; c_y[0] = 4'd0; c_x[1] = 4'd3; c_y[1] = 4'd3;
    feed(0, 256, 0);
    chk("allmax_best", 32'(BestDist), 32'd255);
    chk("allmax_mx", 32'(motionX), 32'd0);
    chk("allmax_my", 32'(motionY), 32'd0);

    // Tie at 50: earlier candidate kept
    idle_low();
    fill(200, 200);
    c_dist[30] = 8'd50; c_x[30] = 4'd2; c_y[30] = 4'd4;
    c_dist[200] = 8'd50; c_x[200] = 4'd9; c_y[200] = 4'd9;
    feed(0, 256, 0);
    chk("tie_best", 32'(BestDist), 32'd50);
    chk("tie_mx", 32'(motionX), 32'd2);
    chk("tie_my", 32'(motionY), 32'd4);

    // Protocol error and pause
    idle_low();
    fill(20, 255);
    feed(0, 10, 0);
    min10 = 255;
    for (int i = 0; i < 10; i++) if (int'(c_dist[i]) < min10) min10 = int'(c_dist[i]);
    cycle(1'b0, 1'b1, 16'h0003, 8'd1, 4'd1, 4'd1);
    chk("perr_flag", 32'(protocol_err), 32'd1);
    chk("perr_cnt", 32'(CandCount), 32'd10);
    chk("perr_best", 32'(BestDist), 32'(min10));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, onehot(i), 8'd0, 4'd0, 4'd0);
    chk("pause_cnt", 32'(CandCount), 32'd10);
    chk("pause_busy", 32'(busy), 32'd1);
    feed(10, 256, 0);
    final_chk("perr_search");
    chk("perr_sticky", 32'(protocol_err), 32'd1);

    // Restart rule: continuous high does not restart
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, onehot(i), 8'd3, 4'd1, 4'd1);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_cnt", 32'(CandCount), 32'd256);
    idle_low();
    fill(0, 255);
    c_dist[0] = 8'd240; c_x[0] = 4'd7; c_y[0] = 4'd2;
    feed(0, 1, 0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_best", 32'(BestDist), 32'd240);
    chk("restart_mx", 32'(motionX), 32'd7);
    chk("restart_perr", 32'(protocol_err), 32'd0);
    chk("restart_cnt", 32'(CandCount), 32'd1);
    feed(1, 256, 0);
    final_chk("restart_search");

    // Reset mid-search
    idle_low();
    fill(100, 100);
    c_dist[50] = 8'd12;
    feed(0, 120, 0);
    chk("mid_best", 32'(BestDist), 32'd12);
    chk("mid_cnt", 32'(CandCount), 32'd120);
    cycle(1'b1, 1'b1, 16'h0001, 8'd1, 4'd5, 4'd5);
    chk("midrst_best", 32'(BestDist), 32'hFF);
    chk("midrst_cnt", 32'(CandCount), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mx", 32'(motionX), 32'd0);
    fill(0, 255);
    feed(0, 256, 0);
    final_chk("post_reset");

    // Randomized searches with gaps, pauses and protocol errors
    for (int r = 0; r < 5; r++) begin
      idle_low();
      fill($urandom_range(250, 0), 255);
      feed(0, 256, 20);
      final_chk("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
